stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter_pkg.sv | 14 +
 rtl/stream_rr_arbiter_rr_priority_encoder.sv | 30 +++
 rtl/stream_rr_arbiter.sv | 164 ++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream round-robin arbiter: FSM state encoding and parameter defaults.
// The optional per-grant beat limit is enabled by defining ARB_BURST_LIMIT_EN.
package stream_rr_arbiter_pkg;

    localparam int DEF_NUM_SRC    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 16;

    typedef enum logic {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } arbState_e;

endpackage

// File: rtl/stream_rr_arbiter_rr_priority_encoder.sv
// Combinational wrap-around priority search: first set request strictly after lastGrant_i, wrapping.
// Gives the source after the previous winner top priority, so every requester is served in turn.
module rr_priority_encoder
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IDX_W-1:0]   lastGrant_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   index_o
);

    // Walk from the farthest candidate to the nearest so the nearest set request overwrites the rest.
    always_comb begin
        int cand;
        cand    = 0;
        index_o = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            cand = (int'(lastGrant_i) + i) % NUM_SRC;
            if (req_i[cand]) begin
                index_o = IDX_W'(cand);
            end
        end
    end

    assign found_o = |req_i;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC valid/ready streams onto one registered output.
// Define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          areset_n,
    input  logic [NUM_SRC-1:0]            i_s_valid,
    output logic [NUM_SRC-1:0]            o_s_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] i_s_data,
    input  logic [NUM_SRC-1:0]            i_s_last,
    output logic                          o_m_valid,
    input  logic                          i_m_ready,
    output logic [DATA_WIDTH-1:0]         o_m_data,
    output logic                          o_m_last,
    output logic [$clog2(NUM_SRC)-1:0]    o_grant_id,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(NUM_SRC);

    arbState_e             state_q, state_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]      lastGrant_q, lastGrant_d;
    logic                  mValid_q, mValid_d;
    logic [DATA_WIDTH-1:0] mData_q, mData_d;
    logic                  mLast_q, mLast_d;

    logic                  reqFound;
    logic [IDX_W-1:0]      reqIdx;
    logic                  wReady;
    logic                  grantValid;
    logic                  grantLast;
    logic [DATA_WIDTH-1:0] grantData;
    logic                  xfer;
    logic                  endGrant;
    logic [NUM_SRC-1:0]    sReady;
    logic                  busy;

    rr_priority_encoder #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) uPriorityEncoder (
        .req_i       (i_s_valid),
        .lastGrant_i (lastGrant_q),
        .found_o     (reqFound),
        .index_o     (reqIdx)
    );

    // A new beat may enter the output register when it is empty or being drained this cycle.
    assign wReady     = i_m_ready | ~mValid_q;
    assign grantValid = i_s_valid[grant_q];
    assign grantLast  = i_s_last[grant_q];
    assign grantData  = i_s_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer       = grantValid & sReady[grant_q];

`ifdef ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;

    // The MAX_BURST-th beat closes the grant exactly like an end-of-packet beat would.
    assign endGrant = xfer & (grantLast | (beatCnt_q == CNT_W'(MAX_BURST - 1)));

    always_comb begin
        beatCnt_d = beatCnt_q;
        if (state_q == S_ARB) begin
            beatCnt_d = '0;
        end else if (xfer) begin
            beatCnt_d = endGrant ? '0 : beatCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            beatCnt_q <= '0;
        end else begin
            beatCnt_q <= beatCnt_d;
        end
    end
`else
    assign endGrant = xfer & grantLast;
`endif

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state_q     <= S_ARB;
            grant_q     <= '0;
            lastGrant_q <= IDX_W'(NUM_SRC - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            S_ARB: begin
                if (reqFound) begin
                    grant_d = reqIdx;
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                if (endGrant) begin
                    state_d     = S_ARB;
                    lastGrant_d = grant_q;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_comb begin
        sReady = '0;
        busy   = 1'b0;
        if (state_q == S_LOCK) begin
            sReady[grant_q] = wReady;
            busy            = 1'b1;
        end
    end

    // Output register drains to empty when nothing arrives and holds under backpressure.
    always_comb begin
        mValid_d = mValid_q;
        mData_d  = mData_q;
        mLast_d  = mLast_q;
        if (wReady) begin
            mValid_d = xfer;
            if (xfer) begin
                mData_d = grantData;
                mLast_d = grantLast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            mValid_q <= 1'b0;
            mData_q  <= '0;
            mLast_q  <= 1'b0;
        end else begin
            mValid_q <= mValid_d;
            mData_q  <= mData_d;
            mLast_q  <= mLast_d;
        end
    end

    assign o_s_ready  = sReady;
    assign o_busy     = busy;
    assign o_grant_id = grant_q;
    assign o_m_valid  = mValid_q;
    assign o_m_data   = mData_q;
    assign o_m_last   = mLast_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed self-checking bench for stream_rr_arbiter (NUM_SRC=4, DATA_WIDTH=8, MAX_BURST=4).
// The beat-limit scenario is compiled in only when ARB_BURST_LIMIT_EN is defined.
module tb_stream_rr_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic        clk;
    logic        areset_n;
    logic [3:0]  sValid;
    logic [3:0]  sReady;
    logic [31:0] sData;
    logic [3:0]  sLast;
    logic        mValid;
    logic        mReady;
    logic [7:0]  mData;
    logic        mLast;
    logic [1:0]  grantId;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    stream_rr_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .i_s_valid  (sValid),
        .o_s_ready  (sReady),
        .i_s_data   (sData),
        .i_s_last   (sLast),
        .o_m_valid  (mValid),
        .i_m_ready  (mReady),
        .o_m_data   (mData),
        .o_m_last   (mLast),
        .o_grant_id (grantId),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last, input logic mRdy);
        sValid = valid;
        sLast  = last;
        mReady = mRdy;
        #1;
    endtask

    task automatic setData(input int src, input logic [7:0] value);
        sData[src*8 +: 8] = value;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkGrant(input string tag, input int g, input int readyExp);
        checkOutput({tag, ".grant"}, 32'(grantId), g);
        checkOutput({tag, ".busy"}, 32'(busy), 1);
        checkOutput({tag, ".ready"}, 32'(sReady), readyExp);
    endtask

    task automatic checkBeat(input string tag, input int data, input int last, input int busyExp);
        checkOutput({tag, ".valid"}, 32'(mValid), 1);
        checkOutput({tag, ".data"}, 32'(mData), data);
        checkOutput({tag, ".last"}, 32'(mLast), last);
        checkOutput({tag, ".busy"}, 32'(busy), busyExp);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".valid"}, 32'(mValid), 0);
        checkOutput({tag, ".data"}, 32'(mData), 0);
        checkOutput({tag, ".last"}, 32'(mLast), 0);
        checkOutput({tag, ".grant"}, 32'(grantId), 0);
        checkOutput({tag, ".busy"}, 32'(busy), 0);
        checkOutput({tag, ".ready"}, 32'(sReady), 0);
    endtask

    task automatic goIdle(input string tag);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick;
        checkOutput({tag, ".idleValid"}, 32'(mValid), 0);
        checkOutput({tag, ".idleBusy"}, 32'(busy), 0);
    endtask

    initial begin
        areset_n = 1'b0;
        sValid   = '0;
        sLast    = '0;
        sData    = '0;
        mReady   = 1'b0;
        tick;
        tick;
        checkResetState("reset");

        // All four sources with single-beat packets: grants rotate 0,1,2,3,0 with an idle cycle between.
        areset_n = 1'b1;
        for (int k = 0; k < 4; k++) setData(k, 8'(8'h10 + k));
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick;
            checkGrant("rr", k % 4, 1 << (k % 4));
            checkOutput("rr.arbValid", 32'(mValid), 0);
            tick;
            checkBeat("rr", 8'h10 + (k % 4), 1, 0);
            checkOutput("rr.arbReady", 32'(sReady), 0);
        end
        goIdle("rr");

        // Lone requester is re-granted after every arbitration cycle.
        for (int n = 0; n < 3; n++) begin
            setData(1, 8'(8'h50 + n));
            applyStimulus(4'b0010, 4'b0010, 1'b1);
            tick;
            checkGrant("single", 1, 4'b0010);
            tick;
            checkBeat("single", 8'h50 + n, 1, 0);
        end
        goIdle("single");

        // Three-beat packet from src 2 stays contiguous while src 1 waits.
        setData(1, 8'h77);
        setData(2, 8'hA1);
        applyStimulus(4'b0110, 4'b0010, 1'b1);
        tick;
        checkGrant("pkt", 2, 4'b0100);
        tick;
        checkBeat("pkt.a1", 8'hA1, 0, 1);
        setData(2, 8'hA2);
        applyStimulus(4'b0110, 4'b0010, 1'b1);
        checkGrant("pkt.mid", 2, 4'b0100);
        tick;
        checkBeat("pkt.a2", 8'hA2, 0, 1);
        setData(2, 8'hA3);
        applyStimulus(4'b0110, 4'b0110, 1'b1);
        tick;
        checkBeat("pkt.a3", 8'hA3, 1, 0);
        applyStimulus(4'b0010, 4'b0010, 1'b1);
        tick;
        checkGrant("pkt.next", 1, 4'b0010);
        tick;
        checkBeat("pkt.src1", 8'h77, 1, 0);
        goIdle("pkt");

        // Reset during the second beat of a src 2 packet; src 0 must win the next arbitration.
        setData(2, 8'hC1);
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        tick;
        checkGrant("rst.pre", 2, 4'b0100);
        tick;
        checkBeat("rst.c1", 8'hC1, 0, 1);
        setData(2, 8'hC2);
        areset_n = 1'b0;
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        tick;
        checkResetState("rst.mid");
        areset_n = 1'b1;
        setData(0, 8'hD0);
        applyStimulus(4'b0111, 4'b0111, 1'b1);
        tick;
        checkGrant("rst.post", 0, 4'b0001);
        checkOutput("rst.noPartial", 32'(mValid), 0);
        tick;
        checkBeat("rst.d0", 8'hD0, 1, 0);
        goIdle("rst");

        // Five stalled cycles mid-packet: output held, source not acknowledged, nothing lost.
        setData(3, 8'hB1);
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        tick;
        checkGrant("stall.pre", 3, 4'b1000);
        tick;
        checkBeat("stall.b1", 8'hB1, 0, 1);
        setData(3, 8'hB2);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        checkOutput("stall.readyLow", 32'(sReady), 0);
        for (int s = 0; s < 5; s++) begin
            tick;
            checkBeat("stall.hold", 8'hB1, 0, 1);
            checkOutput("stall.holdReady", 32'(sReady), 0);
        end
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        checkOutput("stall.readyBack", 32'(sReady), 4'b1000);
        tick;
        checkBeat("stall.b2", 8'hB2, 0, 1);
        setData(3, 8'hB3);
        applyStimulus(4'b1000, 4'b0000, 1'b1);
        tick;
        checkBeat("stall.b3", 8'hB3, 0, 1);
        setData(3, 8'hB4);
        applyStimulus(4'b1000, 4'b1000, 1'b1);
        tick;
        checkBeat("stall.b4", 8'hB4, 1, 0);
        goIdle("stall");

`ifdef ARB_BURST_LIMIT_EN
        // Src 0 streams without last; the fourth beat hands the output to src 3.
        setData(0, 8'hE0);
        setData(3, 8'hF3);
        applyStimulus(4'b1001, 4'b1000, 1'b1);
        tick;
        checkGrant("burst", 0, 4'b0001);
        for (int b = 0; b < 4; b++) begin
            tick;
            checkBeat("burst.beat", 8'hE0 + b, 0, (b < 3) ? 1 : 0);
            setData(0, 8'(8'hE1 + b));
            applyStimulus(4'b1001, 4'b1000, 1'b1);
        end
        tick;
        checkGrant("burst.rotate", 3, 4'b1000);
        tick;
        checkBeat("burst.src3", 8'hF3, 1, 0);
        goIdle("burst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
